seq_divider12: RTL and testbench
================================

// Module: seq_divider12
// PURPOSE
//  Iterative restoring unsigned divider, the inverse operation to the multiplier datapath.
//  Accepts a dividend and divisor on a start pulse and produces quotient and remainder after
//  WIDTH iterations, one bit per clock. Trial subtraction uses a ripple subtractor built from
//  the existing fa cell. Sits beside the multiplier for normalisation/scaling paths.
// PARAMETERS
//  WIDTH  12  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  dividend     in   WIDTH  unsigned dividend, captured when start accepted
//  divisor      in   WIDTH  unsigned divisor, captured when start accepted
//  busy         out  1      high while in RUN
//  done         out  1      one-cycle pulse: results valid
//  quotient     out  WIDTH  unsigned quotient, held until next accepted start
//  remainder    out  WIDTH  unsigned remainder, held until next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held with results
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, quotient=0, remainder=0,
//    div_by_zero=0, iteration counter=0. Reset mid-RUN aborts; no done is produced.
//  - States: IDLE -> RUN (start & divisor!=0) | DONE (start & divisor==0);
//    RUN -> DONE after WIDTH iterations; DONE -> IDLE unconditionally next cycle.
//  - Start accepted at edge E0 (IDLE): latch dividend into Q shift reg, divisor into D,
//    clear partial remainder R (WIDTH+1 bits), count=0, div_by_zero=0.
//  - Each RUN edge: T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D} (WIDTH+1-bit subtract);
//    if no borrow: R=T, Q={Q[WIDTH-2:0],1}; else R={R[WIDTH-1:0],Q[WIDTH-1]}, Q={Q[WIDTH-2:0],0}.
//    count increments; at count==WIDTH-1 the iteration commits quotient=Q', remainder=R'[WIDTH-1:0].
//  - Latency: done=1 in the cycle after edge E0+WIDTH (WIDTH RUN edges); busy=1 from after E0
//    through the final RUN edge, 0 while done=1.
//  - Divide by zero: at E0 go straight to DONE; quotient={WIDTH{1'b1}}, remainder=dividend,
//    div_by_zero=1; done pulses in cycle after E0 (latency 1).
//  - start ignored in RUN and DONE (no queueing); earliest re-accept is first IDLE cycle.
//  - Operand inputs need only be stable at the accepting edge.
//  - All arithmetic unsigned, no overflow possible (R < D invariant after each step).
//  - done never asserted for two consecutive cycles.
// STRUCTURE
//  - Shared package div_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_DONE),
//    default WIDTH, counter width $clog2(WIDTH).
//  - One sub-module: sub_rc (WIDTH+1-bit ripple subtractor, A + ~B + 1 via fa chain,
//    outputs difference and borrow). Control FSM, counter, R/Q/D registers in top.
// TESTING
//  1. 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 12 cycles after start edge.
//  2. 4095/1 -> 4095 r 0; 5/9 -> 0 r 5; 4095/4095 -> 1 r 0; 0/3 -> 0 r 0.
//  3. 1234/0 -> quotient=4095, remainder=1234, div_by_zero=1, done 1 cycle after start, busy never 1.
//  4. start re-asserted every cycle during RUN and DONE -> ignored; next op accepted only in
//     IDLE; operands changed mid-RUN do not affect result of 100/7.
//  5. rst asserted at 5th RUN cycle -> next cycle busy=0, done=0, outputs 0; then 77/5 -> 15 r 2.
//  6. Random 2000 operand pairs vs. reference model (q=a/b, r=a%b); check done pulse width=1.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the iterative restoring divider:
//   - default operand width and matching iteration-counter width
//   - control FSM state encodings
//   - full-adder cell functions used to build the ripple subtractor
package div_pkg;

  localparam int DIV_WIDTH = 12;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  // Full-adder carry-out bit.
  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (ci & (a ^ b));
  endfunction

endpackage

// File: rtl/sub_rc.sv
// sub_rc
//   N-bit ripple subtractor computing a - b as a + ~b + 1 through a chain
//   of full-adder cells.
//   Ports:
//     a      in  N  minuend
//     b      in  N  subtrahend
//     diff   out N  a - b (modulo 2^N)
//     borrow out 1  1 when a < b (inverse of the final carry)
module sub_rc
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic carry;

  // Ripple the carry through one full-adder cell per bit; carry-in of 1 completes two's complement.
  always_comb begin
    diff  = {N{1'b0}};
    carry = 1'b1;
    for (int i = 0; i < N; i++) begin
      diff[i] = fa_sum(a[i], ~b[i], carry);
      carry   = fa_carry(a[i], ~b[i], carry);
    end
    borrow = ~carry;
  end

endmodule

// File: rtl/seq_divider12.sv
// seq_divider12
//   Iterative restoring unsigned divider, one quotient bit per clock.
//   A start in IDLE captures the operands; WIDTH RUN iterations later the
//   quotient and remainder are committed and done pulses for one cycle.
//   A zero divisor skips RUN and reports div_by_zero with done next cycle.
//   Ports:
//     clk         in  1      clock, all state on posedge
//     rst         in  1      synchronous active-high reset
//     start       in  1      request, sampled only in IDLE
//     dividend    in  WIDTH  unsigned dividend, captured on accept
//     divisor     in  WIDTH  unsigned divisor, captured on accept
//     busy        out 1      high while iterating
//     done        out 1      one-cycle result-valid pulse
//     quotient    out WIDTH  quotient, held until next result
//     remainder   out WIDTH  remainder, held until next result
//     div_by_zero out 1      divisor was zero, held with results
module seq_divider12
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q,     state_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [WIDTH:0]   r_q,         r_d;
  logic [WIDTH-1:0] q_q,         q_d;
  logic [WIDTH-1:0] d_q,         d_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             r_msb_unused;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  // R stays below D after every step, so its top bit only matters inside the subtract.
  assign r_msb_unused = r_q[WIDTH];

  sub_rc #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, d_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Next-state logic for the control FSM and the R/Q/D datapath.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = {CW{1'b0}};
          if (divisor == {WIDTH{1'b0}}) begin
            state_d     = ST_DONE;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d = ST_RUN;
            q_d     = dividend;
            d_d     = divisor;
            r_d     = {(WIDTH + 1){1'b0}};
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Restoring step: keep the difference only when the trial did not borrow.
        if (!trial_borrow) begin
          r_d = trial_diff;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end

        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          count_d     = {CW{1'b0}};
          quotient_d  = q_d;
          remainder_d = r_d[WIDTH-1:0];
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= {CW{1'b0}};
      r_q         <= {(WIDTH + 1){1'b0}};
      q_q         <= {WIDTH{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider12.sv
// tb_seq_divider12
//   Scoreboard bench for seq_divider12: the driver pushes the expected
//   result of every accepted operation; a negedge monitor pops and compares
//   whenever done is seen, including latency and done pulse width.
module tb_seq_divider12;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] dividend;
  logic [11:0] divisor;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [11:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic        dbz;
    int          lat;   // edges from accepting edge to the edge that raises done
    int          acc;   // cycle count just after the accepting edge
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  logic prev_done;

  seq_divider12 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL result: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
          end
          checks++;
          if (cyc - e.acc != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d, want %0d", cyc - e.acc, e.lat);
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Wait (bounded) until done is seen at a negedge; starts by looking at the current cycle.
  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL timeout: got no done within 60 cycles, want done");
  endtask

  // Issue one operation from IDLE-or-DONE, push its expectation, wait for its done.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] eq, input logic [11:0] er, input logic edbz);
    exp_t e;
    @(posedge clk);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.lat = edbz ? 0 : 12;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, {31'd0, ~edbz});
    wait_done();
  endtask

  initial begin
    exp_t e;
    logic [11:0] a;
    logic [11:0] b;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    prev_done = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    dividend  = 12'd0;
    divisor   = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", {20'd0, quotient}, 32'd0);
    chk("reset_remainder", {20'd0, remainder}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);

    // Directed vectors with hand-computed results.
    run_op(12'd100,  12'd7,    12'd14,   12'd2,    1'b0);
    run_op(12'd4095, 12'd1,    12'd4095, 12'd0,    1'b0);
    run_op(12'd5,    12'd9,    12'd0,    12'd5,    1'b0);
    run_op(12'd4095, 12'd4095, 12'd1,    12'd0,    1'b0);
    run_op(12'd0,    12'd3,    12'd0,    12'd0,    1'b0);
    run_op(12'd1234, 12'd0,    12'd4095, 12'd1234, 1'b1);
    run_op(12'd100,  12'd7,    12'd14,   12'd2,    1'b0);

    // start held high with changing operands through RUN and DONE.
    @(posedge clk);
    #1;
    dividend = 12'd100;
    divisor  = 12'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.q = 12'd14; e.r = 12'd2; e.dbz = 1'b0; e.lat = 12; e.acc = cyc;
    sb.push_back(e);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
      dividend = 12'($urandom_range(0, 4095));
      divisor  = 12'($urandom_range(0, 4095));
    end
    // Still high in DONE: must only be taken on the following IDLE edge.
    dividend = 12'd77;
    divisor  = 12'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q = 12'd15; e.r = 12'd2; e.dbz = 1'b0; e.lat = 12; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    wait_done();

    // Reset in the 5th RUN cycle aborts the operation without a done.
    @(posedge clk);
    #1;
    dividend = 12'd100;
    divisor  = 12'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {20'd0, quotient}, 32'd0);
    chk("abort_remainder", {20'd0, remainder}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (14) @(negedge clk);
    run_op(12'd77, 12'd5, 12'd15, 12'd2, 1'b0);

    // Random operand pairs against the language's own / and %.
    for (int n = 0; n < 2000; n++) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(1, 4095));
      run_op(a, b, a / b, a % b, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
